// File: rtl/conv_acc_pkg.sv
// Shared definitions for the conv accelerator writeback path: FSM encoding,
// default lane width and a width helper.
package conv_acc_pkg;

    localparam int unsigned LANE_W_DEF = 32;

    typedef enum logic [3:0] {
        StIdle       = 4'd0,
        StInitBuff   = 4'd1,
        StStartConv  = 4'd2,
        StClearStart = 4'd3,
        StWaitAdd    = 4'd4,
        StWaitWrite  = 4'd5,
        StClearCnt   = 4'd6,
        StRow        = 4'd7,
        StDrain      = 4'd8,
        StEnd        = 4'd9
    } wb_state_e;

    // Index width for n items, never below one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_writeback_arb_if.sv
// Serialised beat stream: one beat of N_ROWS lanes plus its channel index,
// with valid/ready flow control.
interface conv_writeback_arb_if #(
    parameter int unsigned N_ROWS = 8,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned CH_W   = 1
);
    logic [N_ROWS*LANE_W-1:0] out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport master (output out_data, output out_ch, output out_valid, input out_ready);
    modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with combinational head read; a push on a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module wb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/conv_writeback_arb.sv
// Writeback control FSM plus per-channel beat capture, FIFO buffering and a
// round-robin arbiter onto a single backpressured output stream.
module conv_writeback_arb
    import conv_acc_pkg::*;
#(
    parameter int unsigned DATA_W     = 25,
    parameter int unsigned LANE_W     = LANE_W_DEF,
    parameter int unsigned N_ROWS     = 8,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DEPTH      = 61,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start_init,
    input  logic                          i_p_filter_end,
    input  logic                          i_end_conv,
    input  logic [N_CH*N_ROWS*DATA_W-1:0] i_ofm_data,
    input  logic [N_CH*N_ROWS-1:0]        i_ofm_valid,
    output logic                          o_p_init,
    output logic                          o_p_write_zero,
    output logic                          o_start_conv,
    output logic                          o_odd_cnt,
    output logic                          o_overflow,
    output logic                          o_end_op,
    conv_writeback_arb_if.master          o_out
);
    localparam int unsigned BEAT_W = N_ROWS * LANE_W;
    localparam int unsigned CH_W   = width_of(N_CH);
    localparam int unsigned CNT_W  = width_of(DEPTH + 3);

    wb_state_e                    r_state;
    logic [CNT_W-1:0]             r_cnt;
    logic                         r_p_init;
    logic                         r_p_write_zero;
    logic                         r_start_conv;
    logic                         r_odd_cnt;
    logic                         r_end_op;
    logic                         r_end_flag;
    logic                         r_overflow;
    logic                         r_out_valid;
    logic [BEAT_W-1:0]            r_out_data;
    logic [CH_W-1:0]              r_out_ch;
    logic [CH_W-1:0]              r_last_grant;

    logic [N_CH-1:0]              w_cap;
    logic [N_CH-1:0]              w_full;
    logic [N_CH-1:0]              w_empty;
    logic [N_CH-1:0]              w_pop;
    logic [N_CH-1:0]              w_drop;
    logic [N_CH-1:0][BEAT_W-1:0]  w_beat;
    logic [N_CH-1:0][BEAT_W-1:0]  w_head;
    logic                         w_load;
    logic                         w_gnt_found;
    logic [CH_W-1:0]              w_gnt_idx;
    logic                         w_cnt_clr;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign w_cap[c] = &i_ofm_valid[c*N_ROWS +: N_ROWS];
        for (genvar r = 0; r < N_ROWS; r++) begin : g_row
            assign w_beat[c][r*LANE_W +: LANE_W] =
                LANE_W'($signed(i_ofm_data[(c*N_ROWS+r)*DATA_W +: DATA_W]));
        end
        assign w_drop[c] = w_cap[c] && w_full[c] && !w_pop[c];

        wb_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_cap[c]),
            .i_pop   (w_pop[c]),
            .i_data  (w_beat[c]),
            .o_data  (w_head[c]),
            .o_full  (w_full[c]),
            .o_empty (w_empty[c])
        );
    end

    // Search starts one past the last granted channel so every channel gets a turn.
    always_comb begin
        int unsigned v_idx;
        v_idx       = 0;
        w_load      = !r_out_valid || o_out.out_ready;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_pop       = '0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            v_idx = (32'(r_last_grant) + k) % N_CH;
            if (!w_gnt_found && !w_empty[CH_W'(v_idx)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = CH_W'(v_idx);
            end
        end
        if (w_load && w_gnt_found) begin
            w_pop[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_last_grant <= '0;
        end else if (w_load) begin
            r_out_valid <= w_gnt_found;
            if (w_gnt_found) begin
                r_out_data   <= w_head[w_gnt_idx];
                r_out_ch     <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= (|w_drop) ||
                          (r_overflow && !(r_state == StIdle && i_start_init));
        end
    end

    assign w_cnt_clr = (r_state == StIdle) || (r_state == StClearStart) ||
                       (r_state == StClearCnt) || (r_state == StDrain);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_p_init       <= 1'b0;
            r_p_write_zero <= 1'b0;
            r_start_conv   <= 1'b0;
            r_odd_cnt      <= 1'b0;
            r_end_op       <= 1'b0;
            r_end_flag     <= 1'b0;
        end else begin
            r_p_init       <= (r_state == StInitBuff);
            r_start_conv   <= (r_state == StStartConv) || (r_state == StClearCnt);
            r_p_write_zero <= (r_state == StRow);
            r_end_op       <= (r_state == StEnd);
            if (r_state == StClearCnt) begin
                r_odd_cnt <= !r_odd_cnt;
            end
            r_end_flag <= i_end_conv || (r_end_flag && (r_state != StDrain));
            r_cnt      <= w_cnt_clr ? '0 : r_cnt + 1'b1;

            case (r_state)
                StIdle:       if (i_start_init) r_state <= StInitBuff;
                StInitBuff:   if (r_cnt == CNT_W'(DEPTH - 1)) r_state <= StStartConv;
                StStartConv:  if (r_cnt >= CNT_W'(DEPTH + 2)) r_state <= StClearStart;
                StClearStart: if (i_p_filter_end) r_state <= StWaitAdd;
                StWaitAdd:    if (r_cnt == CNT_W'(DEPTH - 1)) r_state <= StWaitWrite;
                StWaitWrite:  r_state <= StClearCnt;
                StClearCnt:   r_state <= StRow;
                StRow: begin
                    if (r_cnt == CNT_W'(DEPTH - 1)) begin
                        r_state <= r_end_flag ? StDrain : StClearStart;
                    end
                end
                StDrain:      if ((&w_empty) && !r_out_valid) r_state <= StEnd;
                StEnd:        r_state <= StIdle;
                default:      r_state <= StIdle;
            endcase
        end
    end

    assign o_p_init        = r_p_init;
    assign o_p_write_zero  = r_p_write_zero;
    assign o_start_conv    = r_start_conv;
    assign o_odd_cnt       = r_odd_cnt;
    assign o_overflow      = r_overflow;
    assign o_end_op        = r_end_op;
    assign o_out.out_valid = r_out_valid;
    assign o_out.out_data  = r_out_data;
    assign o_out.out_ch    = r_out_ch;

endmodule

// File: tb/tb_conv_writeback_arb.sv
// Self-checking bench: queue-based reference model of capture/FIFO/arbiter,
// table-driven sign-extension vectors and directed FSM/backpressure sequences.
module tb_conv_writeback_arb;
    import conv_acc_pkg::*;

    localparam int unsigned DATA_W     = 25;
    localparam int unsigned LANE_W     = 32;
    localparam int unsigned N_ROWS     = 8;
    localparam int unsigned N_CH       = 2;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned BEAT_W     = N_ROWS * LANE_W;

    typedef logic [BEAT_W-1:0] beat_t;

    typedef struct {
        int          ch;
        int          row;
        logic [24:0] sv;
        logic [24:0] fv;
        logic [31:0] exp_s;
        logic [31:0] exp_f;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_init = 1'b0;
    logic p_filter_end = 1'b0;
    logic end_conv = 1'b0;
    logic [N_CH*N_ROWS*DATA_W-1:0] ofm_data = '0;
    logic [N_CH*N_ROWS-1:0]        ofm_valid = '0;
    logic p_init, p_write_zero, start_conv, odd_cnt, overflow, end_op;

    conv_writeback_arb_if #(.N_ROWS(N_ROWS), .LANE_W(LANE_W), .CH_W(1)) out_if ();

    conv_writeback_arb #(
        .DATA_W     (DATA_W),
        .LANE_W     (LANE_W),
        .N_ROWS     (N_ROWS),
        .N_CH       (N_CH),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start_init   (start_init),
        .i_p_filter_end (p_filter_end),
        .i_end_conv     (end_conv),
        .i_ofm_data     (ofm_data),
        .i_ofm_valid    (ofm_valid),
        .o_p_init       (p_init),
        .o_p_write_zero (p_write_zero),
        .o_start_conv   (start_conv),
        .o_odd_cnt      (odd_cnt),
        .o_overflow     (overflow),
        .o_end_op       (end_op),
        .o_out          (out_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t mq [N_CH][$];
    logic  m_valid = 1'b0;
    beat_t m_data = '0;
    int    m_ch = 0;
    int    m_last = 0;
    logic  m_ovf = 1'b0;

    int c_pinit, c_sc, c_pwz, c_eop, c_tog;
    logic prev_odd = 1'b0;
    int    log_ch [$];
    logic [31:0] log_l0 [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) mq[c].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_last  = 0;
        m_ovf   = 1'b0;
    endtask

    function automatic beat_t make_beat(input int c);
        beat_t b;
        longint v;
        b = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            v = longint'(ofm_data[(c*N_ROWS+r)*DATA_W +: DATA_W]);
            if (v >= (longint'(1) << (DATA_W - 1))) v = v - (longint'(1) << DATA_W);
            b[r*LANE_W +: LANE_W] = v[31:0];
        end
        return b;
    endfunction

    // One clock edge of the spec: output slot refills from the next channel in
    // turn, then each fully-valid channel appends its beat or is dropped.
    task automatic model_step();
        bit found;
        int idx;
        if (!m_valid || out_if.out_ready) begin
            found = 0;
            for (int k = 1; k <= N_CH; k++) begin
                idx = (m_last + k) % N_CH;
                if (!found && mq[idx].size() > 0) begin
                    found  = 1;
                    m_data = mq[idx].pop_front();
                    m_ch   = idx;
                    m_last = idx;
                end
            end
            m_valid = found;
        end
        if (start_init) m_ovf = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (ofm_valid[c*N_ROWS +: N_ROWS] == {N_ROWS{1'b1}}) begin
                if (mq[c].size() < FIFO_DEPTH) mq[c].push_back(make_beat(c));
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_out();
        check("out_valid", 256'(out_if.out_valid), 256'(m_valid));
        if (m_valid) begin
            check("out_ch", 256'(out_if.out_ch), 256'(m_ch));
            check("out_data", 256'(out_if.out_data), 256'(m_data));
        end
        check("overflow", 256'(overflow), 256'(m_ovf));
        if (p_init) c_pinit++;
        if (start_conv) c_sc++;
        if (p_write_zero) c_pwz++;
        if (end_op) c_eop++;
        if (odd_cnt != prev_odd) c_tog++;
        prev_odd = odd_cnt;
    endtask

    task automatic tick();
        if (out_if.out_valid && out_if.out_ready) begin
            log_ch.push_back(int'(out_if.out_ch));
            log_l0.push_back(out_if.out_data[31:0]);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out();
    endtask

    task automatic clear_counts();
        c_pinit = 0; c_sc = 0; c_pwz = 0; c_eop = 0; c_tog = 0;
    endtask

    task automatic fill_ch(input int c, input logic [24:0] v);
        for (int r = 0; r < N_ROWS; r++) ofm_data[(c*N_ROWS+r)*DATA_W +: DATA_W] = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " p_init"}, 256'(p_init), 256'(0));
        check({tag, " p_write_zero"}, 256'(p_write_zero), 256'(0));
        check({tag, " start_conv"}, 256'(start_conv), 256'(0));
        check({tag, " odd_cnt"}, 256'(odd_cnt), 256'(0));
        check({tag, " overflow"}, 256'(overflow), 256'(0));
        check({tag, " end_op"}, 256'(end_op), 256'(0));
        check({tag, " out_valid"}, 256'(out_if.out_valid), 256'(0));
        check({tag, " out_ch"}, 256'(out_if.out_ch), 256'(0));
        check({tag, " out_data"}, 256'(out_if.out_data), 256'(0));
    endtask

    // Leaves the FSM in WAIT_ADD, the cycle after p_filter_end was taken.
    task automatic start_layer();
        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        repeat (12) tick();
        p_filter_end = 1'b1;
        tick();
        p_filter_end = 1'b0;
    endtask

    vec_t vecs [4];
    logic [255:0] held;

    initial begin
        vecs[0] = '{ch: 0, row: 3, sv: 25'h1000000, fv: 25'h0000005,
                    exp_s: 32'hFF000000, exp_f: 32'h00000005};
        vecs[1] = '{ch: 1, row: 0, sv: 25'h1FFFFFF, fv: 25'h0FFFFFF,
                    exp_s: 32'hFFFFFFFF, exp_f: 32'h00FFFFFF};
        vecs[2] = '{ch: 0, row: 7, sv: 25'h0000000, fv: 25'h1800001,
                    exp_s: 32'h00000000, exp_f: 32'hFF800001};
        vecs[3] = '{ch: 1, row: 5, sv: 25'h0ABCDEF, fv: 25'h1234567,
                    exp_s: 32'h00ABCDEF, exp_f: 32'hFF234567};

        out_if.out_ready = 1'b0;
        clear_counts();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_odd = 1'b0;
        repeat (2) tick();

        // FSM sequence with end_conv during WAIT_ADD.
        clear_counts();
        start_layer();
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        repeat (20) tick();
        check("fsm p_init cycles", 256'(c_pinit), 256'(4));
        check("fsm start_conv cycles", 256'(c_sc), 256'(4));
        check("fsm p_write_zero cycles", 256'(c_pwz), 256'(4));
        check("fsm odd_cnt toggles", 256'(c_tog), 256'(1));
        check("fsm end_op pulses", 256'(c_eop), 256'(1));
        check("fsm back to idle", 256'(dut.r_state), 256'(StIdle));

        // Sign extension vectors, port idle, beat at N+2.
        out_if.out_ready = 1'b1;
        foreach (vecs[i]) begin
            fill_ch(vecs[i].ch, vecs[i].fv);
            ofm_data[(vecs[i].ch*N_ROWS+vecs[i].row)*DATA_W +: DATA_W] = vecs[i].sv;
            ofm_valid[vecs[i].ch*N_ROWS +: N_ROWS] = '1;
            tick();
            ofm_valid = '0;
            tick();
            check("sext out_valid", 256'(out_if.out_valid), 256'(1));
            check("sext out_ch", 256'(out_if.out_ch), 256'(vecs[i].ch));
            for (int r = 0; r < N_ROWS; r++) begin
                check("sext lane", 256'(out_if.out_data[r*LANE_W +: LANE_W]),
                      256'((r == vecs[i].row) ? vecs[i].exp_s : vecs[i].exp_f));
            end
            repeat (2) tick();
        end

        // Round-robin: both channels capture for three cycles.
        log_ch.delete();
        log_l0.delete();
        fill_ch(0, 25'h0000A0);
        fill_ch(1, 25'h0000B1);
        ofm_valid = '1;
        repeat (3) tick();
        ofm_valid = '0;
        repeat (8) tick();
        check("rr beat count", 256'(log_ch.size()), 256'(6));
        for (int i = 0; i < 6 && i < log_ch.size(); i++) begin
            check("rr out_ch order", 256'(log_ch[i]), 256'(i % 2));
        end
        check("rr overflow", 256'(overflow), 256'(0));

        // Backpressure: six ch1 beats, one held, four buffered, one dropped.
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fill_ch(1, 25'(i + 1));
            ofm_valid[N_ROWS +: N_ROWS] = '1;
            tick();
        end
        ofm_valid = '0;
        held = 256'(out_if.out_data);
        repeat (3) tick();
        check("bp data held", 256'(out_if.out_data), held);
        check("bp first beat lane0", 256'(out_if.out_data[31:0]), 256'(1));
        check("bp overflow", 256'(overflow), 256'(1));
        log_ch.delete();
        log_l0.delete();
        out_if.out_ready = 1'b1;
        repeat (10) tick();
        check("bp beat count", 256'(log_l0.size()), 256'(5));
        for (int i = 0; i < 5 && i < log_l0.size(); i++) begin
            check("bp order", 256'(log_l0[i]), 256'(i + 1));
        end
        check("bp drained", 256'(out_if.out_valid), 256'(0));

        // Drain gating: two beats pending when ROW ends with end_conv set.
        out_if.out_ready = 1'b0;
        start_layer();
        clear_counts();
        check("drain ovf cleared", 256'(overflow), 256'(0));
        end_conv = 1'b1;
        fill_ch(0, 25'h11);
        ofm_valid[0 +: N_ROWS] = '1;
        tick();
        end_conv = 1'b0;
        fill_ch(0, 25'h22);
        tick();
        ofm_valid = '0;
        repeat (10) tick();
        check("drain state", 256'(dut.r_state), 256'(StDrain));
        repeat (4) tick();
        check("drain still waiting", 256'(dut.r_state), 256'(StDrain));
        check("drain no end_op", 256'(c_eop), 256'(0));
        log_l0.delete();
        log_ch.delete();
        out_if.out_ready = 1'b1;
        repeat (8) tick();
        check("drain beats taken", 256'(log_l0.size()), 256'(2));
        check("drain end_op pulses", 256'(c_eop), 256'(1));
        check("drain idle", 256'(dut.r_state), 256'(StIdle));

        // Random traffic against the reference model.
        for (int t = 0; t < 300; t++) begin
            for (int c = 0; c < N_CH; c++) begin
                logic [N_ROWS-1:0] m;
                for (int r = 0; r < N_ROWS; r++)
                    ofm_data[(c*N_ROWS+r)*DATA_W +: DATA_W] = 25'($urandom);
                m = N_ROWS'($urandom);
                if ($urandom_range(0, 1) == 1) m = '1;
                ofm_valid[c*N_ROWS +: N_ROWS] = m;
            end
            out_if.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        ofm_valid = '0;
        out_if.out_ready = 1'b1;
        repeat (12) tick();

        // Mid-operation reset while in ROW with beats buffered.
        out_if.out_ready = 1'b0;
        start_layer();
        fill_ch(1, 25'h33);
        ofm_valid[N_ROWS +: N_ROWS] = '1;
        repeat (3) tick();
        ofm_valid = '0;
        repeat (5) tick();
        check("pre-reset in row", 256'(p_write_zero), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        prev_odd = 1'b0;
        out_if.out_ready = 1'b1;
        repeat (3) tick();
        check("post-reset out_valid", 256'(out_if.out_valid), 256'(0));
        check("post-reset idle", 256'(dut.r_state), 256'(StIdle));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
